// File: rtl/params_pkg.sv
// Shared types and sizing for the CPU-side memory port: access sizes,
// arbiter state encoding and the two arbitration clients.
package params_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int CACHE_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    LINE = 2'd3
  } access_size_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    RESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    I = 1'b0,
    D = 1'b1
  } arb_client_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between the I- and D-side requesters.
// Under contention the side that did not win last time is chosen.
module rr_pick2
  import params_pkg::*;
(
  input  logic        i_valid_i,
  input  logic        d_valid_i,
  input  arb_client_t last_grant_i,
  output logic        grant_valid_o,
  output arb_client_t grant_o
);

  always_comb begin
    grant_valid_o = i_valid_i | d_valid_i;
    grant_o       = I;
    if (i_valid_i && d_valid_i) begin
      grant_o = (last_grant_i == I) ? D : I;
    end else if (d_valid_i) begin
      grant_o = D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges I-cache fills and D-cache reads/writes onto the single line-wide
// memory port, holding each request until mem answers and routing the reply.
module mem_port_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH       = params_pkg::ADDR_WIDTH,
  parameter int CACHE_LINE_BYTES = params_pkg::CACHE_LINE_BYTES
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          i_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]         i_req_address_i,
  output logic                          i_resp_valid_o,
  output logic [CACHE_LINE_BYTES*8-1:0] i_resp_data_o,

  input  logic                          d_req_valid_i,
  input  logic                          d_req_is_wr_i,
  input  logic [ADDR_WIDTH-1:0]         d_req_address_i,
  input  logic [CACHE_LINE_BYTES*8-1:0] d_req_wr_data_i,
  input  access_size_t                  d_req_access_size_i,
  output logic                          d_resp_valid_o,
  output logic [CACHE_LINE_BYTES*8-1:0] d_resp_data_o,

  output logic                          rd_req_valid_o,
  output logic                          wr_req_valid_o,
  output logic                          req_is_instr_o,
  output logic [ADDR_WIDTH-1:0]         req_address_o,
  output logic [CACHE_LINE_BYTES*8-1:0] wr_data_o,
  output access_size_t                  req_access_size_o,

  input  logic                          mem_data_valid_i,
  input  logic                          mem_data_is_instr_i,
  input  logic [CACHE_LINE_BYTES*8-1:0] mem_data_i,
  input  logic                          write_done_i,

  output logic                          protocol_error_o
);

  localparam int DW  = CACHE_LINE_BYTES * 8;
  localparam int OFF = $clog2(CACHE_LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;

  arb_state_t              state_q;
  arb_client_t             last_grant_q;
  logic                    rd_req_valid_q;
  logic                    wr_req_valid_q;
  logic                    req_is_instr_q;
  logic [ADDR_WIDTH-1:0]   req_address_q;
  logic [DW-1:0]           wr_data_q;
  access_size_t            req_access_size_q;
  logic                    i_resp_valid_q;
  logic [DW-1:0]           i_resp_data_q;
  logic                    d_resp_valid_q;
  logic [DW-1:0]           d_resp_data_q;
  logic                    protocol_error_q;

  logic                    grant_valid;
  arb_client_t             grant;

  rr_pick2 u_rr_pick2 (
    .i_valid_i     (i_req_valid_i),
    .d_valid_i     (d_req_valid_i),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      last_grant_q      <= I;
      rd_req_valid_q    <= 1'b0;
      wr_req_valid_q    <= 1'b0;
      req_is_instr_q    <= 1'b0;
      req_address_q     <= '0;
      wr_data_q         <= '0;
      req_access_size_q <= BYTE;
      i_resp_valid_q    <= 1'b0;
      i_resp_data_q     <= '0;
      d_resp_valid_q    <= 1'b0;
      d_resp_data_q     <= '0;
      protocol_error_q  <= 1'b0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_data_valid_i || write_done_i) protocol_error_q <= 1'b1;
          if (grant_valid) begin
            if (grant == I) begin
              state_q           <= I_RD;
              rd_req_valid_q    <= 1'b1;
              req_is_instr_q    <= 1'b1;
              req_address_q     <= i_req_address_i & LINE_MASK;
              req_access_size_q <= LINE;
              wr_data_q         <= '0;
            end else begin
              req_is_instr_q    <= 1'b0;
              req_address_q     <= d_req_address_i;
              req_access_size_q <= d_req_access_size_i;
              wr_data_q         <= d_req_wr_data_i;
              if (d_req_is_wr_i) begin
                state_q        <= D_WR;
                wr_req_valid_q <= 1'b1;
              end else begin
                state_q        <= D_RD;
                rd_req_valid_q <= 1'b1;
              end
            end
          end
        end
        I_RD: begin
          if (write_done_i || (mem_data_valid_i && !mem_data_is_instr_i)) protocol_error_q <= 1'b1;
          if (mem_data_valid_i && mem_data_is_instr_i) begin
            state_q        <= RESP;
            rd_req_valid_q <= 1'b0;
            i_resp_valid_q <= 1'b1;
            i_resp_data_q  <= mem_data_i;
            last_grant_q   <= I;
          end
        end
        D_RD: begin
          if (write_done_i || (mem_data_valid_i && mem_data_is_instr_i)) protocol_error_q <= 1'b1;
          if (mem_data_valid_i && !mem_data_is_instr_i) begin
            state_q        <= RESP;
            rd_req_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b1;
            d_resp_data_q  <= mem_data_i;
            last_grant_q   <= D;
          end
        end
        D_WR: begin
          if (mem_data_valid_i) protocol_error_q <= 1'b1;
          if (write_done_i) begin
            state_q        <= RESP;
            wr_req_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b1;
            d_resp_data_q  <= '0;
            last_grant_q   <= D;
          end
        end
        RESP: begin
          // Client valids are still high here; not sampling them avoids a regrant.
          if (mem_data_valid_i || write_done_i) protocol_error_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req_valid_o    = rd_req_valid_q;
  assign wr_req_valid_o    = wr_req_valid_q;
  assign req_is_instr_o    = req_is_instr_q;
  assign req_address_o     = req_address_q;
  assign wr_data_o         = wr_data_q;
  assign req_access_size_o = req_access_size_q;
  assign i_resp_valid_o    = i_resp_valid_q;
  assign i_resp_data_o     = i_resp_data_q;
  assign d_resp_valid_o    = d_resp_valid_q;
  assign d_resp_data_o     = d_resp_data_q;
  assign protocol_error_o  = protocol_error_q;

endmodule
